spi_reg_bridge: RTL and testbench
=================================

Name: spi_reg_bridge

Overview:
- Register-access front end that feeds the SPI master's command port.
- Accepts read/write register requests from a host over a valid/ready interface, buffers them in a small FIFO, and packs each one into a CMD_WIDTH command word. It then issues the word on the SPI master's cmd_in/cmd_vld/cmd_rdy handshake.
- For reads, it waits for the master's read_vld/read_data and returns the result on a response channel, with timeout protection.

Parameters:
ADDR_W, 3, register address width
DATA_W, 8, write data width
CMD_WIDTH, 12, command word width; must equal 1+ADDR_W+DATA_W
READ_WIDTH, 8, SPI read data width
FIFO_DEPTH, 4, request FIFO entries (power of 2, >=2)
TIMEOUT, 1023, max cycles to wait for read_vld after a read command is accepted

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous assert, active-low
req_vld  in  1  host request valid
req_rdy  out  1  request FIFO not full
req_rw  in  1  1=read, 0=write
req_addr  in  ADDR_W  register address
req_wdata  in  DATA_W  write data (ignored for reads)
cmd_out  out  CMD_WIDTH  command word to SPI master cmd_in
cmd_vld  out  1  command valid to SPI master
cmd_rdy  in  1  SPI master ready for command
read_vld  in  1  SPI master read data strobe (1-cycle pulse)
read_data  in  READ_WIDTH  SPI master read data
rsp_vld  out  1  read response valid
rsp_rdy  in  1  host ready for response
rsp_rdata  out  READ_WIDTH  read result (0 on timeout)
rsp_err  out  1  1 = read timed out
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset values: all outputs 0 except req_rdy. Specifically: req_rdy=1, cmd_vld=0, cmd_out=0, rsp_vld=0, rsp_rdata=0, rsp_err=0, busy=0. The FIFO is emptied and the FSM returns to IDLE.
- Reset mid-operation: an in-flight command or response is dropped with no further outputs.
- Request FIFO:
  - Push on req_vld&req_rdy; req_rdy = !full (registered count, no combinational path from req_vld).
  - Entry = {rw, addr, wdata}.
  - Simultaneous push and pop when non-full is legal; count is unchanged.
  - Push when full is impossible because req_rdy=0.
  - Pointers wrap modulo FIFO_DEPTH.
- Command format: cmd_out = {rw, addr, rw ? 0 : wdata}, MSB first.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
  - IDLE: if FIFO non-empty, pop head, load cmd_out, set cmd_vld=1 and go to ISSUE. Otherwise stay.
  - ISSUE: hold cmd_vld and cmd_out stable until cmd_rdy=1. On the handshake edge, drop cmd_vld. If write, go to IDLE. If read, clear the timeout counter and go to WAIT_RD.
  - WAIT_RD:
    - Counter increments each cycle.
    - On read_vld=1: latch rsp_rdata=read_data, rsp_err=0, set rsp_vld=1, go to RESP.
    - Else if counter == TIMEOUT-1: rsp_rdata=0, rsp_err=1, set rsp_vld=1, go to RESP.
    - If read_vld and timeout coincide, data wins (rsp_err=0).
  - RESP: hold rsp_vld, rsp_rdata and rsp_err until rsp_rdy=1. On the handshake edge, clear rsp_vld and go to IDLE.
- Only one outstanding read is allowed. No new command issues until the response is consumed, so a response stalled by rsp_rdy=0 back-pressures the FIFO.
- read_vld outside WAIT_RD is ignored (no state change).
- Latency:
  - Req accepted at edge N with FIFO empty and FSM in IDLE: cmd_vld=1 after edge N+2.
  - Back-to-back writes with cmd_rdy=1 give one command per 2 cycles (ISSUE->IDLE->ISSUE).
  - A read response asserts rsp_vld the cycle after the read_vld edge.
- busy = (count != 0) | (state != IDLE).
- cmd_vld must never drop without cmd_rdy; cmd_out must not change while cmd_vld=1.

Test Plan:
1. Reset, then write req rw=0 addr=3 wdata=0xA5 with cmd_rdy=1 -> cmd_out=0x3A5, cmd_vld high for exactly 1 cycle 2 cycles after accept; no rsp_vld; busy returns 0.
2. Read req addr=5 with cmd_rdy held 0 for 10 cycles -> cmd_out=0xD00 stable with cmd_vld=1 throughout. After cmd_rdy, drive read_vld with read_data=0x3C 20 cycles later -> rsp_vld=1, rsp_rdata=0x3C, rsp_err=0 until rsp_rdy.
3. Read with no read_vld, TIMEOUT=1023 -> rsp_vld=1, rsp_err=1, rsp_rdata=0 exactly 1023 cycles after the cmd handshake; a read_vld pulse injected afterwards is ignored.
4. cmd_rdy=0, push 5 requests -> req_rdy=0 after the 4th accepted entry (FIFO_DEPTH=4; the first entry is popped into ISSUE, so the 5th push is accepted). Release cmd_rdy -> all 5 commands issued in order with no loss or duplication.
5. Read response pending with rsp_rdy=0 and 2 writes queued -> no cmd_vld until rsp_rdy=1, then the writes issue in order.
6. Assert rst_n=0 during WAIT_RD with 2 requests queued -> all outputs at reset values immediately. After release, busy=0 and no command or response is emitted.

Source files
------------

// File: rtl/spi_reg_bridge.sv
// Host register-access front end for an SPI master: requests are queued, packed into
// command words, issued on the master's command handshake, and read results are returned.
module spi_reg_bridge #(
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 8,
    parameter int CMD_WIDTH  = 12,
    parameter int READ_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_rw,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic [CMD_WIDTH-1:0]  cmd_out,
    output logic                  cmd_vld,
    input  logic                  cmd_rdy,
    input  logic                  read_vld,
    input  logic [READ_WIDTH-1:0] read_data,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [READ_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int TO_W    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_e;

    logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  avail_q;
    state_e                state_q;
    logic [TO_W-1:0]       to_cnt_q;
    logic                  cmd_vld_q;
    logic [CMD_WIDTH-1:0]  cmd_out_q;
    logic                  rsp_vld_q;
    logic                  rsp_err_q;
    logic [READ_WIDTH-1:0] rsp_rdata_q;

    logic                  push_s;
    logic                  pop_s;
    logic [ENTRY_W-1:0]    head_s;
    logic                  head_rw_s;
    logic [CMD_WIDTH-1:0]  cmd_word_s;

    assign req_rdy    = (count_q != CNT_W'(FIFO_DEPTH));
    assign push_s     = req_vld && req_rdy;
    assign pop_s      = (state_q == IDLE) && avail_q;
    assign head_s     = mem_q[rd_ptr_q];
    assign head_rw_s  = head_s[ENTRY_W-1];
    // Reads carry no payload, so their data field is forced to zero.
    assign cmd_word_s = CMD_WIDTH'({head_rw_s, head_s[DATA_W +: ADDR_W],
                                    head_rw_s ? DATA_W'(0) : head_s[DATA_W-1:0]});

    assign cmd_out   = cmd_out_q;
    assign cmd_vld   = cmd_vld_q;
    assign rsp_vld   = rsp_vld_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (count_q != CNT_W'(0)) || (state_q != IDLE);

    // Occupancy next-state from push/pop.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Request storage; slots need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {req_rw, req_addr, req_wdata};
        end
    end

    // Pointers and occupancy; avail_q lags the count by one cycle, which only delays a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
            avail_q  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            avail_q <= (count_q != CNT_W'(0));
        end
    end

    // Command issue / read-wait / response FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            to_cnt_q    <= TO_W'(0);
            cmd_vld_q   <= 1'b0;
            cmd_out_q   <= CMD_WIDTH'(0);
            rsp_vld_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= READ_WIDTH'(0);
        end else begin
            case (state_q)
                IDLE: begin
                    if (avail_q) begin
                        cmd_out_q <= cmd_word_s;
                        cmd_vld_q <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_rdy) begin
                        cmd_vld_q <= 1'b0;
                        if (cmd_out_q[CMD_WIDTH-1]) begin
                            to_cnt_q <= TO_W'(0);
                            state_q  <= WAIT_RD;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                WAIT_RD: begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                    // Data arriving on the final cycle still beats the timeout.
                    if (read_vld) begin
                        rsp_rdata_q <= read_data;
                        rsp_err_q   <= 1'b0;
                        rsp_vld_q   <= 1'b1;
                        state_q     <= RESP;
                    end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        rsp_rdata_q <= READ_WIDTH'(0);
                        rsp_err_q   <= 1'b1;
                        rsp_vld_q   <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_rdy) begin
                        rsp_vld_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cmd_vld_q <= 1'b0;
                    rsp_vld_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: directed scenarios plus randomized traffic,
// with an SPI-master responder and a negedge monitor comparing against queued expectations.
module tb_spi_reg_bridge;

    localparam int TIMEOUT = 1023;

    logic        clk;
    logic        rst_n;
    logic        req_vld;
    logic        req_rdy;
    logic        req_rw;
    logic [2:0]  req_addr;
    logic [7:0]  req_wdata;
    logic [11:0] cmd_out;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic        read_vld;
    logic [7:0]  read_data;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int          n_vec = 0;
    int          n_err = 0;
    logic [11:0] exp_cmd_q[$];
    logic [8:0]  exp_rsp_q[$];

    int          slave_delay;
    logic [7:0]  slave_data;
    bit          slave_mute;
    int          sl_d;
    logic [7:0]  sl_dat;
    bit          sl_mute;

    logic        hold_prev;
    logic [11:0] held_cmd;

    spi_reg_bridge #(
        .ADDR_W(3), .DATA_W(8), .CMD_WIDTH(12), .READ_WIDTH(8),
        .FIFO_DEPTH(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .cmd_out(cmd_out), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .read_vld(read_vld), .read_data(read_data),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [11:0] ref_cmd(input logic rw, input logic [2:0] a, input logic [7:0] d);
        logic [7:0] payload;
        payload = rw ? 8'h00 : d;
        return {rw, a, payload};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event observed, expected none (t=%0t)", name, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request and return just after the edge that accepts it (req_vld left high).
    task automatic send(input logic rw, input logic [2:0] a, input logic [7:0] d);
        int guard;
        req_vld = 1'b1; req_rw = rw; req_addr = a; req_wdata = d;
        guard = 0;
        @(negedge clk);
        while (!req_rdy && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!req_rdy) flag("req_accept_budget");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int budget, output int cycles);
        cycles = 0;
        while (!rsp_vld && cycles < budget) begin
            step();
            cycles++;
        end
        if (!rsp_vld) flag("rsp_wait_budget");
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while ((busy || exp_cmd_q.size() != 0 || exp_rsp_q.size() != 0) && c < budget) begin
            step();
            c++;
        end
        chk("drain_idle", {31'd0, (!busy && exp_cmd_q.size() == 0 && exp_rsp_q.size() == 0)}, 32'd1);
    endtask

    // SPI master read responder: records the expected response at the read handshake.
    initial begin
        read_vld  = 1'b0;
        read_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && cmd_vld && cmd_rdy && cmd_out[11]) begin
                sl_d    = slave_delay;
                sl_dat  = slave_data;
                sl_mute = slave_mute;
                if (sl_mute || sl_d + 1 > TIMEOUT) exp_rsp_q.push_back({1'b1, 8'h00});
                else                               exp_rsp_q.push_back({1'b0, sl_dat});
                @(posedge clk);
                if (sl_mute) sl_d = TIMEOUT + 2;
                repeat (sl_d) @(posedge clk);
                #1;
                read_vld  = 1'b1;
                read_data = sl_mute ? 8'hFF : sl_dat;
                @(posedge clk);
                #1;
                read_vld = 1'b0;
            end
        end
    end

    // Monitor: compares every handshake against the scoreboard and checks command stability.
    initial begin
        hold_prev = 1'b0;
        held_cmd  = 12'h000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_cmd_q.delete();
                exp_rsp_q.delete();
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk("cmd_vld_held", {31'd0, cmd_vld}, 32'd1);
                    chk("cmd_out_stable", {20'd0, cmd_out}, {20'd0, held_cmd});
                end
                hold_prev = cmd_vld && !cmd_rdy;
                held_cmd  = cmd_out;
                if (cmd_vld && cmd_rdy) begin
                    if (exp_cmd_q.size() == 0) flag("cmd_unexpected");
                    else chk("cmd_word", {20'd0, cmd_out}, {20'd0, exp_cmd_q.pop_front()});
                end
                if (rsp_vld && rsp_rdy) begin
                    if (exp_rsp_q.size() == 0) flag("rsp_unexpected");
                    else chk("rsp_err_rdata", {23'd0, rsp_err, rsp_rdata}, {23'd0, exp_rsp_q.pop_front()});
                end
                if (req_vld && req_rdy) exp_cmd_q.push_back(ref_cmd(req_rw, req_addr, req_wdata));
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bit quiet;
        rst_n = 1'b0; req_vld = 1'b0; req_rw = 1'b0; req_addr = 3'd0; req_wdata = 8'h00;
        cmd_rdy = 1'b0; rsp_rdy = 1'b0;
        slave_delay = 0; slave_data = 8'h00; slave_mute = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_rdy", {31'd0, req_rdy}, 32'd1);
        chk("rst_cmd_vld", {31'd0, cmd_vld}, 32'd0);
        chk("rst_cmd_out", {20'd0, cmd_out}, 32'd0);
        chk("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
        chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        step();

        // Write: command appears two edges after accept, for exactly one cycle.
        cmd_rdy = 1'b1; rsp_rdy = 1'b1;
        send(1'b0, 3'd3, 8'hA5);
        req_vld = 1'b0;
        step();
        chk("wr_lat_n1", {31'd0, cmd_vld}, 32'd0);
        step();
        chk("wr_lat_n2", {31'd0, cmd_vld}, 32'd1);
        chk("wr_cmd_out", {20'd0, cmd_out}, 32'h3A5);
        step();
        chk("wr_pulse_len", {31'd0, cmd_vld}, 32'd0);
        chk("wr_no_rsp", {31'd0, rsp_vld}, 32'd0);
        step(); step();
        chk("wr_busy_clear", {31'd0, busy}, 32'd0);

        // Read held off by cmd_rdy, then answered after a delay.
        cmd_rdy = 1'b0; rsp_rdy = 1'b0; slave_delay = 20; slave_data = 8'h3C;
        send(1'b1, 3'd5, 8'h77);
        req_vld = 1'b0;
        step(); step();
        for (int i = 0; i < 10; i++) begin
            chk("rd_hold_vld", {31'd0, cmd_vld}, 32'd1);
            chk("rd_hold_out", {20'd0, cmd_out}, 32'hD00);
            step();
        end
        cmd_rdy = 1'b1;
        step();
        cmd_rdy = 1'b0;
        chk("rd_cmd_dropped", {31'd0, cmd_vld}, 32'd0);
        wait_rsp(60, c);
        chk("rd_rsp_latency", c, 32'd21);
        repeat (5) step();
        chk("rd_rsp_hold_vld", {31'd0, rsp_vld}, 32'd1);
        chk("rd_rsp_hold_data", {23'd0, rsp_err, rsp_rdata}, 32'h03C);
        rsp_rdy = 1'b1;
        step();
        rsp_rdy = 1'b0;
        chk("rd_rsp_cleared", {31'd0, rsp_vld}, 32'd0);

        // Timeout with a late, ignored read_vld pulse.
        cmd_rdy = 1'b1; slave_mute = 1'b1;
        send(1'b1, 3'd2, 8'h00);
        req_vld = 1'b0;
        step(); step(); step();
        wait_rsp(1100, c);
        chk("to_latency", c, 32'd1023);
        repeat (5) step();
        chk("to_hold_vld", {31'd0, rsp_vld}, 32'd1);
        chk("to_hold_data", {23'd0, rsp_err, rsp_rdata}, 32'h100);
        rsp_rdy = 1'b1;
        step();
        rsp_rdy = 1'b0; slave_mute = 1'b0;
        step(); step();
        chk("to_busy_clear", {31'd0, busy}, 32'd0);

        // Data on the final timeout cycle wins.
        slave_delay = TIMEOUT - 1; slave_data = 8'h5A;
        send(1'b1, 3'd7, 8'h00);
        req_vld = 1'b0;
        step(); step(); step();
        wait_rsp(1100, c);
        chk("edge_latency", c, 32'd1023);
        chk("edge_data_wins", {23'd0, rsp_err, rsp_rdata}, 32'h05A);
        rsp_rdy = 1'b1;
        step();
        rsp_rdy = 1'b0;

        // FIFO fill while the master stalls: fifth push accepted, then full.
        cmd_rdy = 1'b0; rsp_rdy = 1'b1; slave_delay = 5; slave_data = 8'hC3;
        for (int i = 0; i < 5; i++) send(1'($urandom), 3'($urandom), 8'($urandom));
        req_vld = 1'b0;
        chk("fifo_full", {31'd0, req_rdy}, 32'd0);
        step(); step();
        chk("fifo_still_full", {31'd0, req_rdy}, 32'd0);
        cmd_rdy = 1'b1;
        wait_idle(400);

        // Stalled response back-pressures queued writes.
        rsp_rdy = 1'b0; slave_delay = 3; slave_data = 8'h81;
        send(1'b1, 3'd1, 8'h00);
        send(1'b0, 3'd4, 8'h12);
        send(1'b0, 3'd6, 8'h34);
        req_vld = 1'b0;
        wait_rsp(50, c);
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (cmd_vld) quiet = 1'b0;
            step();
        end
        chk("bp_no_cmd", {31'd0, quiet}, 32'd1);
        rsp_rdy = 1'b1;
        wait_idle(60);

        // Reset during WAIT_RD with writes queued.
        slave_delay = 200; slave_data = 8'h99;
        send(1'b1, 3'd3, 8'h00);
        send(1'b0, 3'd2, 8'h56);
        send(1'b0, 3'd5, 8'h78);
        req_vld = 1'b0;
        repeat (8) step();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd_vld", {31'd0, cmd_vld}, 32'd0);
        chk("mid_rst_cmd_out", {20'd0, cmd_out}, 32'd0);
        chk("mid_rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
        chk("mid_rst_req_rdy", {31'd0, req_rdy}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 260; i++) begin
            step();
            if (busy || cmd_vld || rsp_vld) quiet = 1'b0;
        end
        chk("post_rst_quiet", {31'd0, quiet}, 32'd1);

        // Randomized traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            req_vld     = ($urandom_range(0, 1) == 1);
            req_rw      = 1'($urandom);
            req_addr    = 3'($urandom);
            req_wdata   = 8'($urandom);
            cmd_rdy     = ($urandom_range(0, 9) < 7);
            rsp_rdy     = ($urandom_range(0, 9) < 6);
            slave_delay = $urandom_range(0, 30);
            slave_data  = 8'($urandom);
            step();
        end
        req_vld = 1'b0; cmd_rdy = 1'b1; rsp_rdy = 1'b1;
        wait_idle(600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
